// File: rtl/alu_pkg.sv
// Shared RV32I decode definitions: ALU control word fields, named control
// constants, opcodes, operand-a select codes and the decoded bundle type.
package alu_pkg;

    localparam logic [2:0] SEL_ADD   = 3'd0;
    localparam logic [2:0] SEL_AND   = 3'd1;
    localparam logic [2:0] SEL_XOR   = 3'd2;
    localparam logic [2:0] SEL_SHIFT = 3'd4;
    localparam logic [2:0] SEL_CMP   = 3'd5;

    localparam logic [1:0] GATE_PASS = 2'b00;
    localparam logic [1:0] GATE_INV  = 2'b10;

    localparam logic [1:0] SH_SLL = 2'd1;
    localparam logic [1:0] SH_SRL = 2'd2;
    localparam logic [1:0] SH_SRA = 2'd3;

    localparam logic [2:0] CMP_SIGNED   = 3'b000;
    localparam logic [2:0] CMP_UNSIGNED = 3'b001;

    // Word layout: {invert result, select, b gate, a gate}
    localparam logic [7:0] ALU_ADD  = {1'b0, SEL_ADD,   GATE_PASS, GATE_PASS};
    localparam logic [7:0] ALU_SUB  = {1'b1, SEL_ADD,   GATE_PASS, GATE_INV};
    localparam logic [7:0] ALU_AND  = {1'b0, SEL_AND,   GATE_PASS, GATE_PASS};
    localparam logic [7:0] ALU_OR   = {1'b1, SEL_AND,   GATE_INV,  GATE_INV};
    localparam logic [7:0] ALU_XOR  = {1'b0, SEL_XOR,   GATE_PASS, GATE_PASS};
    localparam logic [7:0] ALU_SLL  = {1'b0, SEL_SHIFT, GATE_PASS, SH_SLL};
    localparam logic [7:0] ALU_SRL  = {1'b0, SEL_SHIFT, GATE_PASS, SH_SRL};
    localparam logic [7:0] ALU_SRA  = {1'b0, SEL_SHIFT, GATE_PASS, SH_SRA};
    localparam logic [7:0] ALU_SLT  = {1'b0, SEL_CMP,   1'b0,      CMP_SIGNED};
    localparam logic [7:0] ALU_SLTU = {1'b0, SEL_CMP,   1'b0,      CMP_UNSIGNED};

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ASEL_RS1  = 2'd0,
        ASEL_PC   = 2'd1,
        ASEL_ZERO = 2'd2
    } a_sel_e;

    typedef struct packed {
        logic [7:0]  alu_ctrl;
        logic [1:0]  a_sel;
        logic        b_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
        logic        jump;
        logic        br_inv;
        logic        illegal;
    } dec_bundle_t;

endpackage

// File: rtl/alu_dec_if.sv
// Fetch-to-decode handshake plus the decoded bundle presented to execute.
interface alu_dec_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [7:0]  alu_ctrl;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic        mem_rd;
    logic        mem_wr;
    logic        branch;
    logic        jump;
    logic        br_inv;
    logic        illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, alu_ctrl, a_sel, b_sel, imm,
               rs1, rs2, rd, rd_we, mem_rd, mem_wr, branch, jump, br_inv, illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, alu_ctrl, a_sel, b_sel, imm,
               rs1, rs2, rd, rd_we, mem_rd, mem_wr, branch, jump, br_inv, illegal
    );
endinterface

// File: rtl/alu_dec_logic.sv
// Combinational RV32I decode: instruction word to ALU control word, operand
// selects, immediate, register addresses and side-band flags.
import alu_pkg::*;

module alu_dec_logic (
    input  logic [31:0] i_instr,
    output dec_bundle_t o_dec
);
    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic        w_ill;

    assign w_opcode = i_instr[6:0];
    assign w_f3     = i_instr[14:12];
    assign w_f7     = i_instr[31:25];
    assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b  = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                       i_instr[11:8], 1'b0};
    assign w_imm_u  = {i_instr[31:12], 12'h000};
    assign w_imm_j  = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                       i_instr[30:21], 1'b0};

    // Opcode/funct decode; an illegal word collapses to a bundle with only the flag set
    always_comb begin
        o_dec       = '0;
        o_dec.rs1   = i_instr[19:15];
        o_dec.rs2   = i_instr[24:20];
        o_dec.rd    = i_instr[11:7];
        w_ill       = 1'b0;
        case (w_opcode)
            OP_LUI: begin
                o_dec.a_sel = ASEL_ZERO;
                o_dec.b_sel = 1'b1;
                o_dec.imm   = w_imm_u;
                o_dec.rd_we = 1'b1;
            end
            OP_AUIPC: begin
                o_dec.a_sel = ASEL_PC;
                o_dec.b_sel = 1'b1;
                o_dec.imm   = w_imm_u;
                o_dec.rd_we = 1'b1;
            end
            OP_JAL: begin
                o_dec.a_sel = ASEL_PC;
                o_dec.b_sel = 1'b1;
                o_dec.imm   = w_imm_j;
                o_dec.jump  = 1'b1;
                o_dec.rd_we = 1'b1;
            end
            OP_JALR: begin
                o_dec.b_sel = 1'b1;
                o_dec.imm   = w_imm_i;
                o_dec.jump  = 1'b1;
                o_dec.rd_we = 1'b1;
                w_ill       = (w_f3 != 3'b000);
            end
            OP_BRANCH: begin
                o_dec.imm    = w_imm_b;
                o_dec.branch = 1'b1;
                o_dec.br_inv = w_f3[0];
                case (w_f3)
                    3'b000, 3'b001: o_dec.alu_ctrl = ALU_XOR;
                    3'b100, 3'b101: o_dec.alu_ctrl = ALU_SLT;
                    3'b110, 3'b111: o_dec.alu_ctrl = ALU_SLTU;
                    default:        w_ill = 1'b1;
                endcase
            end
            OP_LOAD: begin
                o_dec.b_sel  = 1'b1;
                o_dec.imm    = w_imm_i;
                o_dec.mem_rd = 1'b1;
                o_dec.rd_we  = 1'b1;
                w_ill        = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
            end
            OP_STORE: begin
                o_dec.b_sel  = 1'b1;
                o_dec.imm    = w_imm_s;
                o_dec.mem_wr = 1'b1;
                w_ill        = (w_f3 > 3'b010);
            end
            OP_IMM: begin
                o_dec.b_sel = 1'b1;
                o_dec.imm   = w_imm_i;
                o_dec.rd_we = 1'b1;
                case (w_f3)
                    3'b000: o_dec.alu_ctrl = ALU_ADD;
                    3'b010: o_dec.alu_ctrl = ALU_SLT;
                    3'b011: o_dec.alu_ctrl = ALU_SLTU;
                    3'b100: o_dec.alu_ctrl = ALU_XOR;
                    3'b110: o_dec.alu_ctrl = ALU_OR;
                    3'b111: o_dec.alu_ctrl = ALU_AND;
                    3'b001: begin
                        o_dec.alu_ctrl = ALU_SLL;
                        w_ill          = (w_f7 != F7_BASE);
                    end
                    3'b101: begin
                        if (w_f7 == F7_ALT) begin
                            o_dec.alu_ctrl = ALU_SRA;
                        end else begin
                            o_dec.alu_ctrl = ALU_SRL;
                            w_ill          = (w_f7 != F7_BASE);
                        end
                    end
                    default: w_ill = 1'b1;
                endcase
            end
            OP_REG: begin
                o_dec.rd_we = 1'b1;
                case ({w_f7, w_f3})
                    {F7_BASE, 3'b000}: o_dec.alu_ctrl = ALU_ADD;
                    {F7_ALT,  3'b000}: o_dec.alu_ctrl = ALU_SUB;
                    {F7_BASE, 3'b001}: o_dec.alu_ctrl = ALU_SLL;
                    {F7_BASE, 3'b010}: o_dec.alu_ctrl = ALU_SLT;
                    {F7_BASE, 3'b011}: o_dec.alu_ctrl = ALU_SLTU;
                    {F7_BASE, 3'b100}: o_dec.alu_ctrl = ALU_XOR;
                    {F7_BASE, 3'b101}: o_dec.alu_ctrl = ALU_SRL;
                    {F7_ALT,  3'b101}: o_dec.alu_ctrl = ALU_SRA;
                    {F7_BASE, 3'b110}: o_dec.alu_ctrl = ALU_OR;
                    {F7_BASE, 3'b111}: o_dec.alu_ctrl = ALU_AND;
                    default:           w_ill = 1'b1;
                endcase
            end
            default: w_ill = 1'b1;
        endcase

        if (w_ill) begin
            o_dec         = '0;
            o_dec.rs1     = i_instr[19:15];
            o_dec.rs2     = i_instr[24:20];
            o_dec.rd      = i_instr[11:7];
            o_dec.illegal = 1'b1;
        end else begin
            o_dec.rd_we = o_dec.rd_we & (i_instr[11:7] != 5'd0);
        end
    end
endmodule

// File: rtl/alu_dec.sv
// Registered RV32I decode stage. Define ALU_DEC_SKID_EN for the two-entry skid
// buffer with a flopped in_ready; otherwise a single register with pass-through ready.
import alu_pkg::*;

module alu_dec (
    input  logic      clk,
    input  logic      rst_n,
    alu_dec_if.slave  bus
);
    dec_bundle_t w_dec;
    dec_bundle_t r_main;
    logic [31:0] r_main_pc;
    logic        r_main_valid;
    logic        w_accept;
    logic        w_drain;

    alu_dec_logic u_logic (
        .i_instr (bus.in_instr),
        .o_dec   (w_dec)
    );

    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_drain  = r_main_valid && bus.out_ready;

`ifdef ALU_DEC_SKID_EN
    dec_bundle_t r_skid;
    logic [31:0] r_skid_pc;
    logic        r_skid_valid;
    logic        r_in_ready;

    assign bus.in_ready = r_in_ready;

    // Main/skid pair; the skid entry always refills main before new input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main       <= '0;
            r_main_pc    <= 32'h0000_0000;
            r_main_valid <= 1'b0;
            r_skid       <= '0;
            r_skid_pc    <= 32'h0000_0000;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_drain || !r_main_valid) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_pc    <= r_skid_pc;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else if (w_accept) begin
                r_main       <= w_dec;
                r_main_pc    <= bus.in_pc;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_pc    <= bus.in_pc;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end
`else
    assign bus.in_ready = !r_main_valid || bus.out_ready;

    // Single pipeline register, replaced on accept and emptied on drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main       <= '0;
            r_main_pc    <= 32'h0000_0000;
            r_main_valid <= 1'b0;
        end else if (w_accept) begin
            r_main       <= w_dec;
            r_main_pc    <= bus.in_pc;
            r_main_valid <= 1'b1;
        end else if (w_drain) begin
            r_main_valid <= 1'b0;
        end
    end
`endif

    assign bus.out_valid = r_main_valid;
    assign bus.out_pc    = r_main_pc;
    assign bus.alu_ctrl  = r_main.alu_ctrl;
    assign bus.a_sel     = r_main.a_sel;
    assign bus.b_sel     = r_main.b_sel;
    assign bus.imm       = r_main.imm;
    assign bus.rs1       = r_main.rs1;
    assign bus.rs2       = r_main.rs2;
    assign bus.rd        = r_main.rd;
    assign bus.rd_we     = r_main.rd_we;
    assign bus.mem_rd    = r_main.mem_rd;
    assign bus.mem_wr    = r_main.mem_wr;
    assign bus.branch    = r_main.branch;
    assign bus.jump      = r_main.jump;
    assign bus.br_inv    = r_main.br_inv;
    assign bus.illegal   = r_main.illegal;
endmodule

// File: tb/tb_alu_dec.sv
// Directed-vector bench for alu_dec: decode results, handshake ordering and reset.
module tb_alu_dec;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_dec_if bus();

    alu_dec u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        bus.in_instr  = instr;
        bus.in_pc     = pc;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
        total++; if (bus.alu_ctrl !== 8'h00) begin bad++; $display("FAIL rst_alu_ctrl got=%h exp=00", bus.alu_ctrl); end
        total++; if (bus.imm !== 32'h0) begin bad++; $display("FAIL rst_imm got=%h exp=0", bus.imm); end
        total++; if (bus.out_pc !== 32'h0) begin bad++; $display("FAIL rst_out_pc got=%h exp=0", bus.out_pc); end
        total++; if (bus.rd_we !== 1'b0) begin bad++; $display("FAIL rst_rd_we got=%b exp=0", bus.rd_we); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_sub();
        send(32'h402081B3, 32'h0000_1000);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL sub_valid got=%b exp=1", bus.out_valid); end
        total++; if (bus.alu_ctrl !== 8'h82) begin bad++; $display("FAIL sub_ctrl got=%h exp=82", bus.alu_ctrl); end
        total++; if (bus.a_sel !== 2'd0) begin bad++; $display("FAIL sub_a_sel got=%0d exp=0", bus.a_sel); end
        total++; if (bus.b_sel !== 1'b0) begin bad++; $display("FAIL sub_b_sel got=%b exp=0", bus.b_sel); end
        total++; if (bus.rd !== 5'd3) begin bad++; $display("FAIL sub_rd got=%0d exp=3", bus.rd); end
        total++; if (bus.rd_we !== 1'b1) begin bad++; $display("FAIL sub_rd_we got=%b exp=1", bus.rd_we); end
        total++; if (bus.imm !== 32'h0) begin bad++; $display("FAIL sub_imm got=%h exp=0", bus.imm); end
        total++; if (bus.out_pc !== 32'h0000_1000) begin bad++; $display("FAIL sub_pc got=%h exp=1000", bus.out_pc); end
    endtask

    task automatic test_ori();
        send(32'hFFF06293, 32'h0000_1004);
        total++; if (bus.alu_ctrl !== 8'h9A) begin bad++; $display("FAIL ori_ctrl got=%h exp=9a", bus.alu_ctrl); end
        total++; if (bus.b_sel !== 1'b1) begin bad++; $display("FAIL ori_b_sel got=%b exp=1", bus.b_sel); end
        total++; if (bus.imm !== 32'hFFFF_FFFF) begin bad++; $display("FAIL ori_imm got=%h exp=ffffffff", bus.imm); end
        total++; if (bus.rs1 !== 5'd0) begin bad++; $display("FAIL ori_rs1 got=%0d exp=0", bus.rs1); end
        total++; if (bus.rd !== 5'd5) begin bad++; $display("FAIL ori_rd got=%0d exp=5", bus.rd); end
    endtask

    task automatic test_lui();
        send(32'h123450B7, 32'h0000_1008);
        total++; if (bus.alu_ctrl !== 8'h00) begin bad++; $display("FAIL lui_ctrl got=%h exp=00", bus.alu_ctrl); end
        total++; if (bus.a_sel !== 2'd2) begin bad++; $display("FAIL lui_a_sel got=%0d exp=2", bus.a_sel); end
        total++; if (bus.b_sel !== 1'b1) begin bad++; $display("FAIL lui_b_sel got=%b exp=1", bus.b_sel); end
        total++; if (bus.imm !== 32'h1234_5000) begin bad++; $display("FAIL lui_imm got=%h exp=12345000", bus.imm); end
        total++; if (bus.rd_we !== 1'b1) begin bad++; $display("FAIL lui_rd_we got=%b exp=1", bus.rd_we); end
    endtask

    task automatic test_bne();
        send(32'h00209463, 32'h0000_100C);
        total++; if (bus.alu_ctrl !== 8'h20) begin bad++; $display("FAIL bne_ctrl got=%h exp=20", bus.alu_ctrl); end
        total++; if (bus.branch !== 1'b1) begin bad++; $display("FAIL bne_branch got=%b exp=1", bus.branch); end
        total++; if (bus.br_inv !== 1'b1) begin bad++; $display("FAIL bne_br_inv got=%b exp=1", bus.br_inv); end
        total++; if (bus.imm !== 32'h8) begin bad++; $display("FAIL bne_imm got=%h exp=8", bus.imm); end
        total++; if (bus.rd_we !== 1'b0) begin bad++; $display("FAIL bne_rd_we got=%b exp=0", bus.rd_we); end
        total++; if (bus.rs2 !== 5'd2) begin bad++; $display("FAIL bne_rs2 got=%0d exp=2", bus.rs2); end
    endtask

    task automatic test_illegal();
        send(32'h0000_0000, 32'h0000_1010);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL ill_valid got=%b exp=1", bus.out_valid); end
        total++; if (bus.illegal !== 1'b1) begin bad++; $display("FAIL ill_flag got=%b exp=1", bus.illegal); end
        total++; if ({bus.rd_we, bus.mem_rd, bus.mem_wr, bus.branch, bus.jump} !== 5'b0)
            begin bad++; $display("FAIL ill_enables got=%b exp=00000", {bus.rd_we, bus.mem_rd, bus.mem_wr, bus.branch, bus.jump}); end
        total++; if (bus.alu_ctrl !== 8'h00) begin bad++; $display("FAIL ill_ctrl got=%h exp=00", bus.alu_ctrl); end
    endtask

    task automatic test_table();
        logic [31:0] t_instr [11];
        logic [7:0]  t_ctrl  [11];
        logic        t_ill   [11];
        logic [31:0] t_imm   [11];
        t_instr = '{32'h002081B3, 32'h0020F1B3, 32'h0020C1B3, 32'h4020D1B3, 32'h0050B193, 32'h00209193,
                    32'h4020E1B3, 32'h0020D463, 32'h0000B183, 32'h0020A223, 32'h010000EF};
        t_ctrl  = '{8'h00, 8'h10, 8'h20, 8'h43, 8'h51, 8'h41, 8'h00, 8'h50, 8'h00, 8'h00, 8'h00};
        t_ill   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        t_imm   = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd5, 32'd2, 32'd0, 32'd8, 32'd0, 32'd4, 32'd16};
        for (int i = 0; i < 11; i++) begin
            send(t_instr[i], 32'h0000_2000 + 32'(i * 4));
            total++; if (bus.alu_ctrl !== t_ctrl[i]) begin bad++; $display("FAIL tbl_ctrl[%0d] got=%h exp=%h", i, bus.alu_ctrl, t_ctrl[i]); end
            total++; if (bus.illegal !== t_ill[i]) begin bad++; $display("FAIL tbl_ill[%0d] got=%b exp=%b", i, bus.illegal, t_ill[i]); end
            if (!t_ill[i]) begin
                total++; if (bus.imm !== t_imm[i]) begin bad++; $display("FAIL tbl_imm[%0d] got=%h exp=%h", i, bus.imm, t_imm[i]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v_instr [3];
        logic [31:0] v_pc    [3];
        logic [7:0]  v_ctrl  [3];
        logic        exp_rdy [3];
        int idx  = 0;
        int nout = 0;
        int last = -1;
        v_instr = '{32'h002081B3, 32'h0020C1B3, 32'h0020F1B3};
        v_pc    = '{32'h100, 32'h104, 32'h108};
        v_ctrl  = '{8'h00, 8'h20, 8'h10};
`ifdef ALU_DEC_SKID_EN
        exp_rdy = '{1'b1, 1'b1, 1'b0};
`else
        exp_rdy = '{1'b1, 1'b0, 1'b0};
`endif
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 16 && nout < 3; cyc++) begin
            bus.in_valid = (idx < 3);
            if (idx < 3) begin bus.in_instr = v_instr[idx]; bus.in_pc = v_pc[idx]; end
            bus.out_ready = (cyc >= 3);
            @(negedge clk);
            if (cyc < 3) begin
                total++; if (bus.in_ready !== exp_rdy[cyc]) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b exp=%b", cyc, bus.in_ready, exp_rdy[cyc]); end
            end
            if (cyc == 1 || cyc == 2) begin
                total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== v_pc[0])
                    begin bad++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/%h", cyc, bus.out_valid, bus.out_pc, v_pc[0]); end
            end
            if (bus.out_valid && bus.out_ready) begin
                total++; if (bus.out_pc !== v_pc[nout] || bus.alu_ctrl !== v_ctrl[nout])
                    begin bad++; $display("FAIL bp_order[%0d] got=%h/%h exp=%h/%h", nout, bus.out_pc, bus.alu_ctrl, v_pc[nout], v_ctrl[nout]); end
                if (nout > 0) begin
                    total++; if (cyc != last + 1) begin bad++; $display("FAIL bp_gap[%0d] got=%0d exp=%0d", nout, cyc, last + 1); end
                end
                last = cyc;
                nout++;
            end
            if (bus.in_valid && bus.in_ready) idx++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        total++; if (nout != 3) begin bad++; $display("FAIL bp_count got=%0d exp=3", nout); end
    endtask

    task automatic test_reset_mid();
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1; bus.in_instr = 32'h002081B3; bus.in_pc = 32'h300;
        @(posedge clk); #1;
        bus.in_instr  = 32'h0020C1B3; bus.in_pc = 32'h304;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rm_pre_valid got=%b exp=1", bus.out_valid); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rm_async_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rm_async_ready got=%b exp=1", bus.in_ready); end
        @(negedge clk); rst_n = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rm_post_valid[%0d] got=%b exp=0", i, bus.out_valid); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'h0;
        bus.in_pc     = 32'h0;
        bus.out_ready = 1'b0;
        test_reset();
        test_sub();
        test_ori();
        test_lui();
        test_bne();
        test_illegal();
        test_table();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
